hazard_ctrl: RTL and testbench

//  Hazard/stall scheduler for the 5-stage F/D/E/M/W pipeline. Drives the per-stage hold inputs of the pipeline registers, plus flush and EX-operand forwarding selects.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forwarding selects.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-operand forwarding compare for one source register; the M result is younger so it beats W.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] wa_m,
  input  logic [RW-1:0] wa_w,
  input  logic          we_m,
  input  logic          we_w,
  output logic [1:0]    sel
);

  always_comb begin
    sel = FWD_RF;
    if (we_m && (wa_m == ra))
      sel = FWD_M;
    else if (we_w && (wa_w == ra))
      sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler for the F/D/E/M/W pipeline: holds, flushes, EX forwarding
// selects and a saturating count of fetch-stall cycles.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RW      = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    ra1_d,
  input  logic [RW-1:0]    ra2_d,
  input  logic [RW-1:0]    ra1_e,
  input  logic [RW-1:0]    ra2_e,
  input  logic [RW-1:0]    wa_e,
  input  logic [RW-1:0]    wa_m,
  input  logic [RW-1:0]    wa_w,
  input  logic             we_e,
  input  logic             we_m,
  input  logic             we_w,
  input  logic             memtoreg_e,
  input  logic             mul_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  input  logic             branch_taken_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MUL_LAT);

  hz_state_t     state, state_nx;
  logic [CW-1:0] mul_cnt, mul_cnt_nx;
  logic          resume, resume_nx;
  logic          mem_stall, in_mul, load_use;

  fwd_unit #(.RW(RW)) u_fwd_a (
    .ra   (ra1_e),
    .wa_m (wa_m),
    .wa_w (wa_w),
    .we_m (we_m),
    .we_w (we_w),
    .sel  (fwd_a_e)
  );

  fwd_unit #(.RW(RW)) u_fwd_b (
    .ra   (ra2_e),
    .wa_m (wa_m),
    .wa_w (wa_w),
    .we_m (we_m),
    .we_w (we_w),
    .sel  (fwd_b_e)
  );

  // The MEM_WAIT exit cycle behaves like the state it resumes (RUN or MUL_BUSY)
  // with the memory completing, so the multiply count picks up where it froze.
  assign mem_stall = (state == MEM_WAIT) ? !mem_ready : (mem_req_m && !mem_ready);
  assign in_mul    = (state == MUL_BUSY) || ((state == MEM_WAIT) && resume);
  assign load_use  = memtoreg_e && we_e && ((wa_e == ra1_d) || (wa_e == ra2_d));

  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    state_nx   = state;
    mul_cnt_nx = mul_cnt;
    resume_nx  = resume;

    if (mem_stall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      stall_m   = 1'b1;
      state_nx  = MEM_WAIT;
      resume_nx = in_mul;
    end else if (in_mul) begin
      resume_nx = 1'b0;
      if (mul_cnt == CW'(1)) begin
        state_nx   = RUN;
        mul_cnt_nx = '0;
      end else begin
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        stall_e    = 1'b1;
        state_nx   = MUL_BUSY;
        mul_cnt_nx = mul_cnt - CW'(1);
      end
    end else begin
      state_nx  = RUN;
      resume_nx = 1'b0;
      if (mul_e && !branch_taken_e) begin
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        stall_e    = 1'b1;
        state_nx   = MUL_BUSY;
        mul_cnt_nx = CW'(MUL_LAT - 1);
      end else if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      mul_cnt      <= '0;
      resume       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state   <= state_nx;
      mul_cnt <= mul_cnt_nx;
      resume  <= resume_nx;
      if (stall_f && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a 3-bit stall counter makes saturation reachable.
module tb_hazard_ctrl;

  localparam int RW    = 4;
  localparam int CNT_W = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
  logic          we_e, we_m, we_w, memtoreg_e, mul_e, mem_req_m, mem_ready, branch_taken_e;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cycles;
  logic [5:0]    ctl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

  hazard_ctrl #(.RW(RW), .MUL_LAT(3), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ra1_d          (ra1_d),
    .ra2_d          (ra2_d),
    .ra1_e          (ra1_e),
    .ra2_e          (ra2_e),
    .wa_e           (wa_e),
    .wa_m           (wa_m),
    .wa_w           (wa_w),
    .we_e           (we_e),
    .we_m           (we_m),
    .we_w           (we_w),
    .memtoreg_e     (memtoreg_e),
    .mul_e          (mul_e),
    .mem_req_m      (mem_req_m),
    .mem_ready      (mem_ready),
    .branch_taken_e (branch_taken_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .fwd_a_e        (fwd_a_e),
    .fwd_b_e        (fwd_b_e),
    .stall_cycles   (stall_cycles)
  );

  task automatic clear_inputs();
    ra1_d = 4'd0; ra2_d = 4'd0; ra1_e = 4'd0; ra2_e = 4'd0;
    wa_e = 4'd0; wa_m = 4'd0; wa_w = 4'd0;
    we_e = 1'b0; we_m = 1'b0; we_w = 1'b0;
    memtoreg_e = 1'b0; mul_e = 1'b0; mem_req_m = 1'b0;
    mem_ready = 1'b0; branch_taken_e = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL reset_ctl: got %b expected 000000", ctl);
    end
    n_cmp++;
    if (stall_cycles !== 3'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    memtoreg_e = 1'b1; we_e = 1'b1; wa_e = 4'd2; ra1_d = 4'd2; ra2_d = 4'd7;
    #1;
    n_cmp++;
    if (ctl !== 6'b110001) begin
      n_err++; $display("FAIL load_use_ra1: got %b expected 110001", ctl);
    end
    next_cycle();
    memtoreg_e = 1'b0; we_e = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL load_use_after: got %b expected 000000", ctl);
    end
    n_cmp++;
    if (stall_cycles !== 3'd1) begin
      n_err++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cycles);
    end
    memtoreg_e = 1'b1; we_e = 1'b1; wa_e = 4'd5; ra1_d = 4'd1; ra2_d = 4'd5;
    #1;
    n_cmp++;
    if (ctl !== 6'b110001) begin
      n_err++; $display("FAIL load_use_ra2: got %b expected 110001", ctl);
    end
    we_e = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL load_use_no_we: got %b expected 000000", ctl);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_forward();
    clear_inputs();
    we_m = 1'b1; wa_m = 4'd3; we_w = 1'b1; wa_w = 4'd3; ra1_e = 4'd3; ra2_e = 4'd9;
    #1;
    n_cmp++;
    if (fwd_a_e !== 2'b10) begin
      n_err++; $display("FAIL fwd_a_m_wins: got %b expected 10", fwd_a_e);
    end
    n_cmp++;
    if (fwd_b_e !== 2'b00) begin
      n_err++; $display("FAIL fwd_b_none: got %b expected 00", fwd_b_e);
    end
    we_m = 1'b0;
    #1;
    n_cmp++;
    if (fwd_a_e !== 2'b01) begin
      n_err++; $display("FAIL fwd_a_w: got %b expected 01", fwd_a_e);
    end
    we_m = 1'b1; wa_m = 4'd9; wa_w = 4'd4;
    #1;
    n_cmp++;
    if (fwd_b_e !== 2'b10) begin
      n_err++; $display("FAIL fwd_b_m: got %b expected 10", fwd_b_e);
    end
    n_cmp++;
    if (fwd_a_e !== 2'b00) begin
      n_err++; $display("FAIL fwd_a_rf: got %b expected 00", fwd_a_e);
    end
    wa_m = 4'd0; ra1_e = 4'd0;
    #1;
    n_cmp++;
    if (fwd_a_e !== 2'b10) begin
      n_err++; $display("FAIL fwd_a_r0: got %b expected 10", fwd_a_e);
    end
    clear_inputs();
  endtask

  task automatic test_mul();
    do_reset();
    mul_e = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b111000) begin
      n_err++; $display("FAIL mul_c0: got %b expected 111000", ctl);
    end
    next_cycle();
    memtoreg_e = 1'b1; we_e = 1'b1; wa_e = 4'd6; ra1_d = 4'd6;
    #1;
    n_cmp++;
    if (ctl !== 6'b111000) begin
      n_err++; $display("FAIL mul_c1_masked: got %b expected 111000", ctl);
    end
    next_cycle();
    memtoreg_e = 1'b0; we_e = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL mul_release: got %b expected 000000", ctl);
    end
    next_cycle();
    mul_e = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL mul_after: got %b expected 000000", ctl);
    end
    n_cmp++;
    if (stall_cycles !== 3'd2) begin
      n_err++; $display("FAIL mul_cnt: got %0d expected 2", stall_cycles);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL mem_ready_now: got %b expected 000000", ctl);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (ctl !== 6'b111100) begin
        n_err++; $display("FAIL mem_wait_c%0d: got %b expected 111100", i, ctl);
      end
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL mem_release: got %b expected 000000", ctl);
    end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== 3'd4) begin
      n_err++; $display("FAIL mem_cnt: got %0d expected 4", stall_cycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_e = 1'b1; memtoreg_e = 1'b1; we_e = 1'b1; wa_e = 4'd8; ra2_d = 4'd8;
    #1;
    n_cmp++;
    if (ctl !== 6'b000011) begin
      n_err++; $display("FAIL branch_over_lu: got %b expected 000011", ctl);
    end
    memtoreg_e = 1'b0; mul_e = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000011) begin
      n_err++; $display("FAIL branch_over_mul: got %b expected 000011", ctl);
    end
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL branch_no_mul: got %b expected 000000", ctl);
    end
    n_cmp++;
    if (stall_cycles !== 3'd0) begin
      n_err++; $display("FAIL branch_cnt: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_mem_in_mul();
    logic [5:0] exp_seq [6];
    exp_seq = '{6'b111000, 6'b111100, 6'b111100, 6'b111000, 6'b000000, 6'b000000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mul_e     = (i < 5);
      mem_req_m = (i >= 1) && (i <= 3);
      mem_ready = (i == 3);
      #1;
      n_cmp++;
      if (ctl !== exp_seq[i]) begin
        n_err++; $display("FAIL mem_in_mul_c%0d: got %b expected %b", i, ctl, exp_seq[i]);
      end
      next_cycle();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== 3'd4) begin
      n_err++; $display("FAIL mem_in_mul_cnt: got %0d expected 4", stall_cycles);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mem_req_m = 1'b1;
    repeat (9) next_cycle();
    #1;
    n_cmp++;
    if (stall_cycles !== 3'd7) begin
      n_err++; $display("FAIL sat_cnt: got %0d expected 7", stall_cycles);
    end
    mem_ready = 1'b1;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    mul_e = 1'b1;
    next_cycle();
    mul_e = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 6'b111000) begin
      n_err++; $display("FAIL rst_mul_busy: got %b expected 111000", ctl);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL rst_mul_ctl: got %b expected 000000", ctl);
    end
    n_cmp++;
    if (stall_cycles !== 3'd0) begin
      n_err++; $display("FAIL rst_mul_cnt: got %0d expected 0", stall_cycles);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL rst_mul_after: got %b expected 000000", ctl);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_forward();
    test_mul();
    test_mem_wait();
    test_branch();
    test_mem_in_mul();
    test_saturate();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
